// File: rtl/cnn_pkg.sv
// Shared CNN front-end types: default pixel width, 3x3 window array and the
// window-generator state encoding.
package cnn_pkg;

  localparam int unsigned CNN_DATA_W = 16;
  localparam int unsigned WIN_N      = 9;

  typedef logic signed [CNN_DATA_W-1:0] pixel_t;

  // Index 0..8 = TL,TM,TR,ML,MM,MR,BL,BM,BR
  typedef pixel_t window_t [WIN_N];

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } cw_state_e;

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: combinational read of the addressed entry, write of the
// same entry on enable, so the old value is seen before it is replaced.
module line_buffer #(
  parameter  int unsigned DEPTH = 28,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout_c
);

  // Storage is never reset: every entry is rewritten before it reaches a valid window
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_dout_c = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[i_addr] <= i_din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order pixel stream to registered 3x3 sliding window generator
// (valid convolution, no padding) with per-frame completion pulse.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned DATA_W = CNN_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] pixel_in,
  input  logic                     pixel_valid,
  output logic signed [DATA_W-1:0] window [WIN_N],
  output logic                     valid_out,
  output logic                     frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  cw_state_e                r_state, w_state_nxt;
  logic [COL_W-1:0]         r_col, w_col_nxt;
  logic [ROW_W-1:0]         r_row, w_row_nxt;
  logic signed [DATA_W-1:0] r_window [WIN_N];
  logic                     r_valid, w_valid_nxt;
  logic                     r_done, w_done_nxt;

  logic                     w_accept;
  logic                     w_last_col;
  logic                     w_last_row;
  logic signed [DATA_W-1:0] w_lb1;
  logic signed [DATA_W-1:0] w_lb2;

  assign w_accept   = pixel_valid & ~clear;
  assign w_last_col = (r_col == COL_W'(IMG_W - 1));
  assign w_last_row = (r_row == ROW_W'(IMG_H - 1));

  // lb1 returns the previous row at this column, lb2 the row above that
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
    .clk      (clk),
    .i_en     (w_accept),
    .i_addr   (r_col),
    .i_din    (pixel_in),
    .o_dout_c (w_lb1)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb2 (
    .clk      (clk),
    .i_en     (w_accept),
    .i_addr   (r_col),
    .i_din    (w_lb1),
    .o_dout_c (w_lb2)
  );

  // Next-state, position counters and next output flags
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    if (clear) begin
      w_state_nxt = ST_FILL;
      w_col_nxt   = '0;
      w_row_nxt   = '0;
    end else if (pixel_valid) begin
      w_valid_nxt = (r_state == ST_RUN) && (r_col >= COL_W'(2));
      w_done_nxt  = w_valid_nxt && w_last_col && w_last_row;
      if (w_last_col) begin
        w_col_nxt = '0;
        w_row_nxt = w_last_row ? '0 : r_row + ROW_W'(1);
      end else begin
        w_col_nxt = r_col + COL_W'(1);
      end
      case (r_state)
        ST_FILL: if (w_last_col && (r_row == ROW_W'(1))) w_state_nxt = ST_RUN;
        ST_RUN:  if (w_last_col && w_last_row)           w_state_nxt = ST_FILL;
        default: w_state_nxt = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FILL;
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Shift window left one column; new right column comes from lb2/lb1/input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_window <= '{default: '0};
    end else if (w_accept) begin
      r_window[0] <= r_window[1];
      r_window[1] <= r_window[2];
      r_window[2] <= w_lb2;
      r_window[3] <= r_window[4];
      r_window[4] <= r_window[5];
      r_window[5] <= w_lb1;
      r_window[6] <= r_window[7];
      r_window[7] <= r_window[8];
      r_window[8] <= pixel_in;
    end
  end

  assign window     = r_window;
  assign valid_out  = r_valid;
  assign frame_done = r_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 4x4 scenarios with hand-computed windows
// and a 28x28 signed-extremes frame against an image-array model.
module tb_conv_window_gen;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             clr4, pv4, vo4, fd4;
  logic signed [15:0] px4;
  window_t          win4;

  logic             clr28, pv28, vo28, fd28;
  logic signed [15:0] px28;
  window_t          win28;

  int n_vec = 0;
  int n_err = 0;

  int exp4 [4][9] = '{'{1, 2, 3, 5, 6, 7, 9, 10, 11},
                      '{2, 3, 4, 6, 7, 8, 10, 11, 12},
                      '{5, 6, 7, 9, 10, 11, 13, 14, 15},
                      '{6, 7, 8, 10, 11, 12, 14, 15, 16}};
  int pix28 [784];

  conv_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(16)) dut4 (
    .clk(clk), .reset(rst), .clear(clr4), .pixel_in(px4), .pixel_valid(pv4),
    .window(win4), .valid_out(vo4), .frame_done(fd4)
  );

  conv_window_gen #(.IMG_W(28), .IMG_H(28), .DATA_W(16)) dut28 (
    .clk(clk), .reset(rst), .clear(clr28), .pixel_in(px28), .pixel_valid(pv28),
    .window(win28), .valid_out(vo28), .frame_done(fd28)
  );

  task automatic step4(input int v, input logic vld, input logic clr);
    px4 = 16'(v); pv4 = vld; clr4 = clr;
    @(posedge clk); #1;
  endtask

  task automatic step28(input int v, input logic vld);
    px28 = 16'(v); pv28 = vld; clr28 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; clr4 = 1'b0; pv4 = 1'b0; px4 = '0; clr28 = 1'b0; pv28 = 1'b0; px28 = '0;
    #1;
    n_vec++; if (vo4 !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", vo4); end
    n_vec++; if (fd4 !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", fd4); end
    for (int j = 0; j < 9; j++) begin
      n_vec++; if (win4[j] !== 16'sd0) begin n_err++; $display("FAIL reset_win[%0d] got=%0d exp=0", j, win4[j]); end
    end
    n_vec++; if (vo28 !== 1'b0) begin n_err++; $display("FAIL reset_valid28 got=%b exp=0", vo28); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_continuous;
    int k = 0;
    logic ev;
    for (int p = 1; p <= 16; p++) begin
      step4(p, 1'b1, 1'b0);
      ev = ((p - 1) / 4 >= 2) && ((p - 1) % 4 >= 2);
      n_vec++; if (vo4 !== ev) begin n_err++; $display("FAIL cont_valid p=%0d got=%b exp=%b", p, vo4, ev); end
      n_vec++; if (fd4 !== logic'(p == 16)) begin n_err++; $display("FAIL cont_done p=%0d got=%b exp=%b", p, fd4, p == 16); end
      if (ev) begin
        for (int j = 0; j < 9; j++) begin
          n_vec++;
          if (win4[j] !== 16'(exp4[k][j])) begin n_err++; $display("FAIL cont_win w%0d[%0d] got=%0d exp=%0d", k, j, win4[j], exp4[k][j]); end
        end
        k++;
      end
    end
    step4(0, 1'b0, 1'b0);
    n_vec++; if (vo4 !== 1'b0) begin n_err++; $display("FAIL cont_idle_valid got=%b exp=0", vo4); end
  endtask

  task automatic test_gaps;
    int k = 0;
    int nv = 0;
    logic ev;
    window_t snap;
    for (int p = 1; p <= 16; p++) begin
      step4(p, 1'b1, 1'b0);
      ev = ((p - 1) / 4 >= 2) && ((p - 1) % 4 >= 2);
      if (vo4 === 1'b1) nv++;
      n_vec++; if (vo4 !== ev) begin n_err++; $display("FAIL gap_valid p=%0d got=%b exp=%b", p, vo4, ev); end
      if (ev) begin
        for (int j = 0; j < 9; j++) begin
          n_vec++;
          if (win4[j] !== 16'(exp4[k][j])) begin n_err++; $display("FAIL gap_win w%0d[%0d] got=%0d exp=%0d", k, j, win4[j], exp4[k][j]); end
        end
        k++;
      end
      snap = win4;
      step4(0, 1'b0, 1'b0);
      if (vo4 === 1'b1) nv++;
      n_vec++; if (vo4 !== 1'b0) begin n_err++; $display("FAIL gap_idle_valid p=%0d got=%b exp=0", p, vo4); end
      n_vec++; if (fd4 !== 1'b0) begin n_err++; $display("FAIL gap_idle_done p=%0d got=%b exp=0", p, fd4); end
      for (int j = 0; j < 9; j++) begin
        n_vec++;
        if (win4[j] !== snap[j]) begin n_err++; $display("FAIL gap_hold p=%0d [%0d] got=%0d exp=%0d", p, j, win4[j], snap[j]); end
      end
    end
    n_vec++; if (nv !== 4) begin n_err++; $display("FAIL gap_count got=%0d exp=4", nv); end
  endtask

  task automatic test_back_to_back;
    int nv = 0;
    int nd = 0;
    int b, r, c, e;
    logic ev;
    for (int i = 0; i < 32; i++) begin
      b = (i < 16) ? 0 : 100;
      r = (i % 16) / 4;
      c = i % 4;
      step4(b + r * 4 + c + 1, 1'b1, 1'b0);
      ev = (r >= 2) && (c >= 2);
      if (vo4 === 1'b1) nv++;
      if (fd4 === 1'b1) nd++;
      n_vec++; if (vo4 !== ev) begin n_err++; $display("FAIL b2b_valid i=%0d got=%b exp=%b", i, vo4, ev); end
      if (ev) begin
        for (int j = 0; j < 9; j++) begin
          e = b + (r - 2 + j / 3) * 4 + (c - 2 + j % 3) + 1;
          n_vec++;
          if (win4[j] !== 16'(e)) begin n_err++; $display("FAIL b2b_win i=%0d [%0d] got=%0d exp=%0d", i, j, win4[j], e); end
        end
      end
    end
    n_vec++; if (nv !== 8) begin n_err++; $display("FAIL b2b_count got=%0d exp=8", nv); end
    n_vec++; if (nd !== 2) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
  endtask

  task automatic test_reset_mid;
    int k = 0;
    logic ev;
    for (int p = 1; p <= 10; p++) begin
      step4(p, 1'b1, 1'b0);
      n_vec++; if (vo4 !== 1'b0) begin n_err++; $display("FAIL rmid_pre_valid p=%0d got=%b exp=0", p, vo4); end
    end
    pv4 = 1'b0;
    rst = 1'b1;
    #1;
    for (int j = 0; j < 9; j++) begin
      n_vec++; if (win4[j] !== 16'sd0) begin n_err++; $display("FAIL rmid_win_clr[%0d] got=%0d exp=0", j, win4[j]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int p = 1; p <= 16; p++) begin
      step4(p, 1'b1, 1'b0);
      ev = ((p - 1) / 4 >= 2) && ((p - 1) % 4 >= 2);
      n_vec++; if (vo4 !== ev) begin n_err++; $display("FAIL rmid_valid p=%0d got=%b exp=%b", p, vo4, ev); end
      n_vec++; if (fd4 !== logic'(p == 16)) begin n_err++; $display("FAIL rmid_done p=%0d got=%b exp=%b", p, fd4, p == 16); end
      if (ev) begin
        for (int j = 0; j < 9; j++) begin
          n_vec++;
          if (win4[j] !== 16'(exp4[k][j])) begin n_err++; $display("FAIL rmid_win w%0d[%0d] got=%0d exp=%0d", k, j, win4[j], exp4[k][j]); end
        end
        k++;
      end
    end
  endtask

  task automatic test_clear_mid;
    int k = 0;
    logic ev;
    for (int p = 1; p <= 6; p++) begin
      step4(p, 1'b1, 1'b0);
      n_vec++; if (vo4 !== 1'b0) begin n_err++; $display("FAIL clr_pre_valid p=%0d got=%b exp=0", p, vo4); end
    end
    step4(7, 1'b1, 1'b1);
    n_vec++; if (vo4 !== 1'b0) begin n_err++; $display("FAIL clr_edge_valid got=%b exp=0", vo4); end
    n_vec++; if (fd4 !== 1'b0) begin n_err++; $display("FAIL clr_edge_done got=%b exp=0", fd4); end
    for (int p = 1; p <= 16; p++) begin
      step4(p, 1'b1, 1'b0);
      ev = ((p - 1) / 4 >= 2) && ((p - 1) % 4 >= 2);
      n_vec++; if (vo4 !== ev) begin n_err++; $display("FAIL clr_valid p=%0d got=%b exp=%b", p, vo4, ev); end
      n_vec++; if (fd4 !== logic'(p == 16)) begin n_err++; $display("FAIL clr_done p=%0d got=%b exp=%b", p, fd4, p == 16); end
      if (ev) begin
        for (int j = 0; j < 9; j++) begin
          n_vec++;
          if (win4[j] !== 16'(exp4[k][j])) begin n_err++; $display("FAIL clr_win w%0d[%0d] got=%0d exp=%0d", k, j, win4[j], exp4[k][j]); end
        end
        k++;
      end
    end
    step4(0, 1'b0, 1'b0);
  endtask

  task automatic test_full_frame;
    int nv = 0;
    int r, c, e;
    logic ev;
    for (int i = 0; i < 784; i++) begin
      case (i % 4)
        0:       pix28[i] = -32768;
        1:       pix28[i] = 32767;
        2:       pix28[i] = i * 37 - 15000;
        default: pix28[i] = -(i * 41);
      endcase
    end
    for (int i = 0; i < 784; i++) begin
      r = i / 28;
      c = i % 28;
      step28(pix28[i], 1'b1);
      ev = (r >= 2) && (c >= 2);
      if (vo28 === 1'b1) nv++;
      n_vec++; if (vo28 !== ev) begin n_err++; $display("FAIL f28_valid i=%0d got=%b exp=%b", i, vo28, ev); end
      n_vec++; if (fd28 !== logic'(i == 783)) begin n_err++; $display("FAIL f28_done i=%0d got=%b exp=%b", i, fd28, i == 783); end
      if (ev) begin
        for (int j = 0; j < 9; j++) begin
          e = pix28[(r - 2 + j / 3) * 28 + (c - 2 + j % 3)];
          n_vec++;
          if (win28[j] !== 16'(e)) begin n_err++; $display("FAIL f28_win i=%0d [%0d] got=%0d exp=%0d", i, j, win28[j], e); end
        end
      end
    end
    step28(0, 1'b0);
    n_vec++; if (vo28 !== 1'b0) begin n_err++; $display("FAIL f28_idle_valid got=%b exp=0", vo28); end
    n_vec++; if (nv !== 676) begin n_err++; $display("FAIL f28_count got=%0d exp=676", nv); end
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_gaps;
    test_back_to_back;
    test_reset_mid;
    test_clear_mid;
    test_full_frame;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
